sensor_debounce: RTL and testbench

//   Conditions the raw satellite sensor pins before the sensor latch/shift chain.

---
 rtl/sensor_debounce.sv | 86 ++++++++
 tb/tb_sensor_debounce.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - sensor pad synchroniser, per-bit debouncer and frame activity latch
// Feeds sensorInput of the logic top; frameStart clears activity latched during the previous frame.
module sensor_debounce #(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_CYC = 2048,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic             masterClk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] sensorRaw,
    input  logic             frameStart,
    output logic [WIDTH-1:0] sensorStable,
    output logic [WIDTH-1:0] sensorOut,
    output logic             changed
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [WIDTH-1:0] PAD_IDLE  = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_act;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_lvl;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;

    // Sync stages idle at the pad's inactive level so no spurious edge follows reset.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= PAD_IDLE;
            r_sync2 <= PAD_IDLE;
        end else begin
            r_sync1 <= sensorRaw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl  = r_sync2 ^ PAD_IDLE;
    assign w_diff = w_lvl ^ r_stable;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A rise in the same cycle as frameStart survives so the next frame still reports it.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_stable  <= '0;
            r_act     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_stable  <= r_stable ^ w_accept;
            r_act     <= (r_act & ~{WIDTH{frameStart}}) | (w_accept & w_lvl);
            r_changed <= |w_accept;
        end
    end

    assign sensorStable = r_stable;
    assign sensorOut    = r_stable | r_act;
    assign changed      = r_changed;

endmodule

// File: tb/tb_sensor_debounce.sv
// tb/tb_sensor_debounce.sv - directed self-checking bench for sensor_debounce
module tb_sensor_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] raw;
    logic       fs;
    logic [7:0] stable;
    logic [7:0] sout;
    logic       chg;

    int total;
    int bad;

    sensor_debounce #(
        .WIDTH        (8),
        .DEBOUNCE_CYC (4),
        .ACTIVE_LOW   (1'b0)
    ) u_dut (
        .masterClk    (clk),
        .nReset       (rst_n),
        .sensorRaw    (raw),
        .frameStart   (fs),
        .sensorStable (stable),
        .sensorOut    (sout),
        .changed      (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        raw   = 8'h00;
        fs    = 1'b0;

        // 1: reset state and quiet pads
        step(3);
        check("rst_stable", 32'(stable), 32'h00);
        check("rst_out", 32'(sout), 32'h00);
        check("rst_changed", 32'(chg), 32'h0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen = seen | chg | (|stable) | (|sout);
        end
        check("idle_activity", 32'(seen), 32'h0);

        // 2: clean edge on bit 0, six-cycle latency
        raw[0] = 1'b1;
        step(5);
        check("b0_before", 32'(stable), 32'h00);
        check("b0_chg_before", 32'(chg), 32'h0);
        step(1);
        check("b0_accept", 32'(stable), 32'h01);
        check("b0_chg", 32'(chg), 32'h1);
        check("b0_out", 32'(sout), 32'h01);
        step(1);
        check("b0_chg_once", 32'(chg), 32'h0);

        // 3: 3-cycle glitch on bit 3 rejected
        raw[3] = 1'b1;
        step(3);
        raw[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | stable[3] | sout[3] | chg;
            step(1);
        end
        check("b3_glitch", 32'(seen), 32'h0);

        // 4: bit 5 active 10 cycles, latch holds it until frameStart
        raw[5] = 1'b1;
        step(6);
        check("b5_accept", 32'(stable), 32'h21);
        step(4);
        raw[5] = 1'b0;
        step(5);
        check("b5_still", 32'(stable[5]), 32'h1);
        step(1);
        check("b5_release", 32'(stable), 32'h01);
        check("b5_latched", 32'(sout), 32'h21);
        check("b5_fall_chg", 32'(chg), 32'h1);
        step(3);
        check("b5_hold", 32'(sout), 32'h21);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        check("b5_cleared", 32'(sout), 32'h01);

        // 5: frameStart coincides with bit 2 rising; set wins
        raw[2] = 1'b1;
        step(5);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        check("b2_accept", 32'(stable), 32'h05);
        check("b2_out", 32'(sout), 32'h05);
        raw[2] = 1'b0;
        step(6);
        check("b2_released", 32'(stable), 32'h01);
        check("b2_latched", 32'(sout), 32'h05);
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        check("b2_cleared", 32'(sout), 32'h01);

        // 6: async reset mid-count, then full re-acceptance
        raw = 8'hFF;
        step(6);
        check("all_accept", 32'(stable), 32'hFF);
        check("all_chg", 32'(chg), 32'h1);
        step(1);
        check("all_chg_once", 32'(chg), 32'h0);
        raw = 8'h00;
        step(3);
        raw   = 8'hFF;
        rst_n = 1'b0;
        #1;
        check("async_stable", 32'(stable), 32'h00);
        check("async_out", 32'(sout), 32'h00);
        check("async_chg", 32'(chg), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("reacc_before", 32'(stable), 32'h00);
        step(1);
        check("reacc_stable", 32'(stable), 32'hFF);
        check("reacc_out", 32'(sout), 32'hFF);
        check("reacc_chg", 32'(chg), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
